// File: rtl/port_demux_pkg.sv
// Shared definitions for the output-side port distributor: port priority decode
// and FIFO occupancy width.
package port_demux_pkg;

  localparam int unsigned MAXP      = 32;
  localparam int unsigned DEF_DEPTH = 4;

  function automatic int unsigned count_w(input int unsigned depth);
    return $clog2(depth + 1);
  endfunction

  localparam int unsigned CW = count_w(DEF_DEPTH);

  // Lowest set bit wins; an all-zero select routes to the last port.
  function automatic int unsigned prio_sel(input logic [MAXP-1:0] index,
                                           input int unsigned nport);
    int unsigned sel;
    logic        found;
    sel   = nport - 1;
    found = 1'b0;
    for (int unsigned i = 0; i < nport; i++) begin
      if (index[i] && !found) begin
        sel   = i;
        found = 1'b1;
      end
    end
    return sel;
  endfunction

endpackage

// File: rtl/port_demux_if.sv
// Input stream and per-port output bundle of the port distributor.
interface port_demux_if #(
  parameter int unsigned NPORT = 5,
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  logic                   in_valid;
  logic                   in_ready;
  logic [WIDTH-1:0]       in_data;
  logic [NPORT-1:0]       index;
  logic [NPORT-1:0]       out_valid;
  logic [NPORT-1:0]       out_ready;
  logic [NPORT*WIDTH-1:0] out_data;
  logic [NPORT*CNT_W-1:0] out_count;

  modport master (
    output in_valid, in_data, index, out_ready,
    input  in_ready, out_valid, out_data, out_count
  );

  modport slave (
    input  in_valid, in_data, index, out_ready,
    output in_ready, out_valid, out_data, out_count
  );
endinterface

// File: rtl/port_fifo.sv
// Single-port output FIFO; head data reads as zero when empty.
module port_fifo
  import port_demux_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic [WIDTH-1:0]           din,
  output logic                       full,
  input  logic                       pop,
  output logic                       valid,
  output logic [WIDTH-1:0]           dout,
  output logic [$clog2(DEPTH+1)-1:0] count
);
  localparam int unsigned CNT_W = count_w(DEPTH);
  localparam int unsigned AW    = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wptr;
  logic [AW-1:0]    rptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CNT_W'(DEPTH));
  assign valid   = (count != '0);
  assign do_push = push && !full;
  assign do_pop  = pop && valid;
  assign dout    = valid ? mem[rptr] : '0;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop)  rptr <= rptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset: dout is masked by valid.
  always_ff @(posedge clk) begin
    if (do_push) mem[wptr] <= din;
  end

endmodule

// File: rtl/port_demux.sv
// Steers one valid/ready flit stream into NPORT per-port FIFOs by priority select.
module port_demux
  import port_demux_pkg::*;
#(
  parameter int unsigned NPORT = 5,
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  port_demux_if.slave  bus
);
  localparam int unsigned CNT_W = count_w(DEPTH);
  localparam int unsigned SW    = (NPORT > 1) ? $clog2(NPORT) : 1;

  logic [MAXP-1:0]  index_ext;
  logic [SW-1:0]    sel;
  logic [NPORT-1:0] full;
  logic [NPORT-1:0] push;

  assign index_ext    = MAXP'(bus.index);
  assign sel          = SW'(prio_sel(index_ext, NPORT));
  assign bus.in_ready = !full[sel];

  always_comb begin
    push      = '0;
    push[sel] = bus.in_valid && bus.in_ready;
  end

  for (genvar p = 0; p < NPORT; p++) begin : g_port
    port_fifo #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH)
    ) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (push[p]),
      .din   (bus.in_data),
      .full  (full[p]),
      .pop   (bus.out_ready[p]),
      .valid (bus.out_valid[p]),
      .dout  (bus.out_data[WIDTH*p +: WIDTH]),
      .count (bus.out_count[CNT_W*p +: CNT_W])
    );
  end

endmodule
